usbbuff_pingpong_ctrl: RTL and testbench
========================================

USBBUFF_PINGPONG_CTRL -- requirements
Module: usbbuff_pingpong_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the buffer address width (256-byte dual-port buffer).
REQ-002 Parameter HALF_DEPTH, default 128, SHALL set the bytes per ping-pong half (2**(ADDR_W-1)).
REQ-003 CLK  in  1  SHALL be the system clock; all logic is rising-edge.
REQ-004 RST  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 ENA  in  1  SHALL be the capture enable; when low, no samples are accepted.
REQ-006 SAMPLE_VALID  in  1  SHALL flag one valid averaged sample on DIN this cycle.
REQ-007 DIN  in  8  SHALL carry the averaged sample.
REQ-008 WENA, WADDR[7:0], WDATA[7:0]  out  SHALL drive the buffer write port.
REQ-009 USB_REQ  out  1  SHALL request the USB transmitter to drain a half.
REQ-010 USB_HALF  out  1  SHALL identify the offered half (0 = addresses 0-127, 1 = addresses 128-255).
REQ-011 USB_ACK  in  1  SHALL be the transmitter's acceptance of USB_REQ.
REQ-012 USB_RDY  in  1  SHALL be the transmitter's per-byte read strobe.
REQ-013 RENA, RADDR[7:0]  out  SHALL drive the buffer read port.
REQ-014 USB_DONE  out  1  SHALL pulse for one cycle when a half has been drained.
REQ-015 OVERRUN  out  1  SHALL be a sticky dropped-sample flag; CLR_OVR  in  1  SHALL clear it.
REQ-016 DROP_CNT  out  8  SHALL count dropped samples, saturating at 255.

Function
REQ-017 The block SHALL keep a write pointer wp[7:0], a read half selector rd_half, and flags full[1:0].
REQ-018 A sample SHALL be accepted when ENA=1, SAMPLE_VALID=1 and full[wp[7]]=0.
REQ-019 On the cycle after acceptance: WENA=1, WADDR=wp (pre-increment value), WDATA=DIN; wp then increments, wrapping 255->0.
REQ-020 An accepted write at offset HALF_DEPTH-1 of a half (wp=127 or 255) SHALL set full[] for that half.
REQ-021 A sample arriving with ENA=1 while full[wp[7]]=1 SHALL be dropped: no write, wp held, OVERRUN set, DROP_CNT incremented (saturating).
REQ-022 The read FSM SHALL have the states IDLE, REQ, XFER and DONE.
REQ-023 IDLE->REQ SHALL occur when full[rd_half]=1; in REQ, USB_REQ=1 and USB_HALF=rd_half.
REQ-024 REQ->XFER SHALL occur on USB_ACK=1; RADDR SHALL load {rd_half, 7'd0}; USB_REQ SHALL be 0 from XFER onward.
REQ-025 In XFER, RENA SHALL equal USB_RDY combinationally, and RADDR SHALL increment on each edge with USB_RDY=1.
REQ-026 The 128th read (RADDR offset 127) SHALL move XFER->DONE.
REQ-027 DONE SHALL last one cycle: USB_DONE=1, clear full[rd_half], toggle rd_half, then return to IDLE.
REQ-028 If the DONE clear and a write into the same half coincide, the clear SHALL take effect first and the write SHALL be accepted.
REQ-029 If CLR_OVR and a drop coincide, OVERRUN SHALL stay 1; CLR_OVR SHALL NOT clear DROP_CNT.
REQ-030 ENA low SHALL freeze wp only; the read FSM SHALL keep draining full halves.

Reset
REQ-031 While RST=1 the outputs SHALL be: WENA=0, WADDR=0, WDATA=0, USB_REQ=0, USB_HALF=0, RENA=0, RADDR=0, USB_DONE=0, OVERRUN=0, DROP_CNT=0.
REQ-032 While RST=1 the internal state SHALL be: wp=0, rd_half=0, full=2'b00, FSM in IDLE.
REQ-033 Reset asserted mid-XFER SHALL abort the transfer and discard both halves.

Structure
REQ-034 The package usbbuff_pkg SHALL hold HALF_DEPTH, the address width and the read FSM state encoding.
REQ-035 The read FSM and read pointer SHALL be one sub-module, usbbuff_rd_fsm; write-side logic stays in the top.

Verification
REQ-036 Reset, then 128 samples (ENA=1) -> WADDR 0..127, full=01, USB_REQ=1, USB_HALF=0.
REQ-037 Hold USB_ACK, then USB_RDY for 128 cycles -> RADDR 0..127, USB_DONE pulses once, full[0]=0, rd_half=1.
REQ-038 Write 256 samples with no USB activity, then one more sample -> dropped, OVERRUN=1, DROP_CNT=1, wp=0.
REQ-039 Apply CLR_OVR and a drop in the same cycle -> OVERRUN stays 1, DROP_CNT=2.
REQ-040 Land a DONE for half 0 in the same cycle as a write to address 0 -> write accepted, WADDR=0, full[0]=0.
REQ-041 Assert RST at RADDR=60 in XFER -> all outputs at reset values; the next full half is offered as half 0.

Source files
------------

// File: rtl/usbbuff_pkg.sv
// Shared constants and read-side state encoding for the USB ping-pong buffer controller.
package usbbuff_pkg;

    // 256-byte dual-port buffer split into two 128-byte halves.
    localparam int BUF_ADDR_W     = 8;
    localparam int BUF_HALF_DEPTH = 128;

    // Read FSM: wait for a full half, offer it, stream it out, report completion.
    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_REQ  = 2'd1,
        RD_XFER = 2'd2,
        RD_DONE = 2'd3
    } rd_state_e;

endpackage

// File: rtl/usbbuff_rd_fsm.sv
// Read side: offers a full half to the USB transmitter, walks the read pointer
// across it on each USB_RDY strobe, then releases the half and swaps to the other.
module usbbuff_rd_fsm
    import usbbuff_pkg::*;
#(
    parameter int ADDR_W     = BUF_ADDR_W,
    parameter int HALF_DEPTH = BUF_HALF_DEPTH
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        full_i,
    input  logic              usb_ack_i,
    input  logic              usb_rdy_i,
    output logic              usb_req_o,
    output logic              rd_half_o,
    output logic              rena_o,
    output logic [ADDR_W-1:0] raddr_o,
    output logic              done_o
);

    localparam int                OFFS_W    = ADDR_W - 1;
    localparam logic [OFFS_W-1:0] LAST_OFFS = OFFS_W'(HALF_DEPTH - 1);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              rd_half_q, rd_half_d;

    // Next-state and handshake outputs for the read FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        raddr_d   = raddr_q;
        rd_half_d = rd_half_q;
        usb_req_o = 1'b0;
        rena_o    = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (full_i[rd_half_q]) state_d = RD_REQ;
            end
            RD_REQ: begin
                usb_req_o = 1'b1;
                if (usb_ack_i) begin
                    state_d = RD_XFER;
                    raddr_d = {rd_half_q, {OFFS_W{1'b0}}};
                end
            end
            RD_XFER: begin
                rena_o = usb_rdy_i;
                if (usb_rdy_i) begin
                    raddr_d = raddr_q + ADDR_W'(1);
                    if (raddr_q[OFFS_W-1:0] == LAST_OFFS) state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                done_o    = 1'b1;
                rd_half_d = ~rd_half_q;
                state_d   = RD_IDLE;
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // State, read pointer and half selector; reset abandons any transfer in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= RD_IDLE;
            raddr_q   <= '0;
            rd_half_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            raddr_q   <= raddr_d;
            rd_half_q <= rd_half_d;
        end
    end

    assign raddr_o   = raddr_q;
    assign rd_half_o = rd_half_q;

endmodule

// File: rtl/usbbuff_pingpong_ctrl.sv
// Ping-pong capture buffer controller: writes averaged samples into alternating
// halves of a dual-port buffer and hands each full half to the USB transmitter.
module usbbuff_pingpong_ctrl
    import usbbuff_pkg::*;
#(
    parameter int ADDR_W     = BUF_ADDR_W,
    parameter int HALF_DEPTH = BUF_HALF_DEPTH
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENA,
    input  logic              SAMPLE_VALID,
    input  logic [7:0]        DIN,
    output logic              WENA,
    output logic [ADDR_W-1:0] WADDR,
    output logic [7:0]        WDATA,
    output logic              USB_REQ,
    output logic              USB_HALF,
    input  logic              USB_ACK,
    input  logic              USB_RDY,
    output logic              RENA,
    output logic [ADDR_W-1:0] RADDR,
    output logic              USB_DONE,
    output logic              OVERRUN,
    input  logic              CLR_OVR,
    output logic [7:0]        DROP_CNT
);

    localparam int                OFFS_W    = ADDR_W - 1;
    localparam logic [OFFS_W-1:0] LAST_OFFS = OFFS_W'(HALF_DEPTH - 1);

    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [1:0]        full_q, full_d;
    logic              wena_q, wena_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              ovr_q, ovr_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic       rd_done;
    logic       rd_half;
    logic [1:0] clr_mask;
    logic [1:0] full_eff;
    logic       wr_half;
    logic       accept;
    logic       drop;

    usbbuff_rd_fsm #(
        .ADDR_W     (ADDR_W),
        .HALF_DEPTH (HALF_DEPTH)
    ) u_rd_fsm (
        .CLK       (CLK),
        .RST       (RST),
        .full_i    (full_q),
        .usb_ack_i (USB_ACK),
        .usb_rdy_i (USB_RDY),
        .usb_req_o (USB_REQ),
        .rd_half_o (rd_half),
        .rena_o    (RENA),
        .raddr_o   (RADDR),
        .done_o    (rd_done)
    );

    // Write acceptance, full-flag bookkeeping and overrun accounting.
    always_comb begin
        // A half released by the reader this cycle is already writable this cycle.
        clr_mask          = 2'b00;
        clr_mask[rd_half] = rd_done;
        full_eff          = full_q & ~clr_mask;

        wr_half = wp_q[ADDR_W-1];
        accept  = ENA & SAMPLE_VALID & ~full_eff[wr_half];
        drop    = ENA & SAMPLE_VALID &  full_eff[wr_half];

        wp_d       = wp_q;
        full_d     = full_eff;
        wena_d     = accept;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        ovr_d      = ovr_q;
        drop_cnt_d = drop_cnt_q;

        if (accept) begin
            waddr_d = wp_q;
            wdata_d = DIN;
            wp_d    = wp_q + ADDR_W'(1);
            if (wp_q[OFFS_W-1:0] == LAST_OFFS) full_d[wr_half] = 1'b1;
        end

        // A drop in the same cycle as a clear wins, so no overrun is lost.
        if (CLR_OVR) ovr_d = 1'b0;
        if (drop) begin
            ovr_d = 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Write-side registers; reset empties both halves.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wp_q       <= '0;
            full_q     <= 2'b00;
            wena_q     <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            ovr_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wp_q       <= wp_d;
            full_q     <= full_d;
            wena_q     <= wena_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            ovr_q      <= ovr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign WENA     = wena_q;
    assign WADDR    = waddr_q;
    assign WDATA    = wdata_q;
    assign USB_HALF = rd_half;
    assign USB_DONE = rd_done;
    assign OVERRUN  = ovr_q;
    assign DROP_CNT = drop_cnt_q;

endmodule

// File: tb/tb_usbbuff_pingpong_ctrl.sv
// Self-checking bench for usbbuff_pingpong_ctrl: expected buffer writes and reads
// are queued as stimulus is driven and compared when the DUT strobes WENA/RENA.
module tb_usbbuff_pingpong_ctrl;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       ENA = 1'b0;
    logic       SAMPLE_VALID = 1'b0;
    logic [7:0] DIN = 8'h00;
    logic       USB_ACK = 1'b0;
    logic       USB_RDY = 1'b0;
    logic       CLR_OVR = 1'b0;
    logic       WENA;
    logic [7:0] WADDR;
    logic [7:0] WDATA;
    logic       USB_REQ;
    logic       USB_HALF;
    logic       RENA;
    logic [7:0] RADDR;
    logic       USB_DONE;
    logic       OVERRUN;
    logic [7:0] DROP_CNT;

    int n_checks   = 0;
    int n_fail     = 0;
    int done_seen  = 0;
    wr_t        wr_q[$];
    logic [7:0] rd_q[$];

    usbbuff_pingpong_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .ENA          (ENA),
        .SAMPLE_VALID (SAMPLE_VALID),
        .DIN          (DIN),
        .WENA         (WENA),
        .WADDR        (WADDR),
        .WDATA        (WDATA),
        .USB_REQ      (USB_REQ),
        .USB_HALF     (USB_HALF),
        .USB_ACK      (USB_ACK),
        .USB_RDY      (USB_RDY),
        .RENA         (RENA),
        .RADDR        (RADDR),
        .USB_DONE     (USB_DONE),
        .OVERRUN      (OVERRUN),
        .CLR_OVR      (CLR_OVR),
        .DROP_CNT     (DROP_CNT)
    );

    always #5 CLK = ~CLK;

    // Scoreboard: pop and compare on the falling edge, away from the active edge.
    always @(negedge CLK) begin
        if (!RST) begin
            if (WENA) begin
                n_checks++;
                if (wr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL write_unexpected: got WADDR=%0d WDATA=%h, expected no write", WADDR, WDATA);
                end else begin
                    wr_t exp_w;
                    exp_w = wr_q.pop_front();
                    if ({WADDR, WDATA} !== exp_w) begin
                        n_fail++;
                        $display("FAIL write: got WADDR=%0d WDATA=%h, expected WADDR=%0d WDATA=%h",
                                 WADDR, WDATA, exp_w.addr, exp_w.data);
                    end
                end
            end
            if (RENA) begin
                n_checks++;
                if (rd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL read_unexpected: got RADDR=%0d, expected no read", RADDR);
                end else begin
                    logic [7:0] exp_r;
                    exp_r = rd_q.pop_front();
                    if (RADDR !== exp_r) begin
                        n_fail++;
                        $display("FAIL read: got RADDR=%0d, expected %0d", RADDR, exp_r);
                    end
                end
            end
            if (USB_DONE) done_seen++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_dut();
        RST          = 1'b1;
        ENA          = 1'b0;
        SAMPLE_VALID = 1'b0;
        USB_ACK      = 1'b0;
        USB_RDY      = 1'b0;
        CLR_OVR      = 1'b0;
        repeat (2) tick();
        RST = 1'b0;
        wr_q.delete();
        rd_q.delete();
        tick();
    endtask

    // Drive n back-to-back samples expected to land at consecutive addresses.
    task automatic write_samples(input int n, input int start_addr);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            ENA          = 1'b1;
            SAMPLE_VALID = 1'b1;
            DIN          = 8'($urandom);
            e.addr       = 8'(start_addr + i);
            e.data       = DIN;
            wr_q.push_back(e);
            tick();
        end
        SAMPLE_VALID = 1'b0;
    endtask

    // Accept the offered half and strobe n reads starting at base; leaves USB_RDY low.
    task automatic drain_half(input logic [7:0] base, input int n);
        USB_ACK = 1'b1;
        tick();
        USB_ACK = 1'b0;
        n_checks++;
        if (USB_REQ !== 1'b0) begin
            n_fail++;
            $display("FAIL req_after_ack: got USB_REQ=%b, expected 0", USB_REQ);
        end
        for (int i = 0; i < n; i++) begin
            USB_RDY = 1'b1;
            rd_q.push_back(8'(base + i));
            tick();
        end
        USB_RDY = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        n_checks++;
        if ({WENA, WADDR, WDATA} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_write_port: got WENA=%b WADDR=%0d WDATA=%h, expected all 0", WENA, WADDR, WDATA);
        end
        n_checks++;
        if ({USB_REQ, USB_HALF, RENA, RADDR, USB_DONE} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_read_port: got REQ=%b HALF=%b RENA=%b RADDR=%0d DONE=%b, expected all 0",
                     USB_REQ, USB_HALF, RENA, RADDR, USB_DONE);
        end
        n_checks++;
        if ({OVERRUN, DROP_CNT} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_status: got OVERRUN=%b DROP_CNT=%0d, expected 0/0", OVERRUN, DROP_CNT);
        end
        reset_dut();
    endtask

    task automatic test_fill_half0();
        write_samples(128, 0);
        tick();
        n_checks++;
        if (wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL fill0_writes: got %0d writes missing, expected 0", wr_q.size());
        end
        n_checks++;
        if (dut.full_q !== 2'b01) begin
            n_fail++;
            $display("FAIL fill0_full: got full=%b, expected 01", dut.full_q);
        end
        n_checks++;
        if ({USB_REQ, USB_HALF} !== 2'b10) begin
            n_fail++;
            $display("FAIL fill0_req: got USB_REQ=%b USB_HALF=%b, expected 1/0", USB_REQ, USB_HALF);
        end
    endtask

    task automatic test_drain();
        int done_before;
        done_before = done_seen;
        drain_half(8'd0, 128);
        n_checks++;
        if (USB_DONE !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_done: got USB_DONE=%b, expected 1", USB_DONE);
        end
        tick();
        n_checks++;
        if (USB_DONE !== 1'b0 || (done_seen - done_before) != 1) begin
            n_fail++;
            $display("FAIL drain_done_pulse: got USB_DONE=%b pulses=%0d, expected 0 and 1 pulse",
                     USB_DONE, done_seen - done_before);
        end
        n_checks++;
        if (rd_q.size() != 0 || dut.full_q[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_release: got %0d reads missing full0=%b, expected 0/0", rd_q.size(), dut.full_q[0]);
        end
        // Filling the upper half must get it offered, proving the reader moved to half 1.
        write_samples(128, 128);
        tick();
        n_checks++;
        if ({USB_REQ, USB_HALF} !== 2'b11 || wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_next_half: got USB_REQ=%b USB_HALF=%b pending=%0d, expected 1/1/0",
                     USB_REQ, USB_HALF, wr_q.size());
        end
    endtask

    task automatic test_overrun();
        reset_dut();
        write_samples(256, 0);
        tick();
        n_checks++;
        if (dut.full_q !== 2'b11 || wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL ovr_fill: got full=%b pending=%0d, expected 11/0", dut.full_q, wr_q.size());
        end
        ENA          = 1'b1;
        SAMPLE_VALID = 1'b1;
        DIN          = 8'hA5;
        tick();
        SAMPLE_VALID = 1'b0;
        n_checks++;
        if (WENA !== 1'b0 || OVERRUN !== 1'b1 || DROP_CNT !== 8'd1) begin
            n_fail++;
            $display("FAIL ovr_drop: got WENA=%b OVERRUN=%b DROP_CNT=%0d, expected 0/1/1", WENA, OVERRUN, DROP_CNT);
        end
        n_checks++;
        if (dut.wp_q !== 8'd0) begin
            n_fail++;
            $display("FAIL ovr_wp: got wp=%0d, expected 0", dut.wp_q);
        end
    endtask

    task automatic test_clr_ovr_drop();
        CLR_OVR      = 1'b1;
        SAMPLE_VALID = 1'b1;
        tick();
        CLR_OVR      = 1'b0;
        SAMPLE_VALID = 1'b0;
        n_checks++;
        if (OVERRUN !== 1'b1 || DROP_CNT !== 8'd2) begin
            n_fail++;
            $display("FAIL clr_with_drop: got OVERRUN=%b DROP_CNT=%0d, expected 1/2", OVERRUN, DROP_CNT);
        end
        CLR_OVR = 1'b1;
        tick();
        CLR_OVR = 1'b0;
        n_checks++;
        if (OVERRUN !== 1'b0 || DROP_CNT !== 8'd2) begin
            n_fail++;
            $display("FAIL clr_alone: got OVERRUN=%b DROP_CNT=%0d, expected 0/2", OVERRUN, DROP_CNT);
        end
    endtask

    task automatic test_done_write_collide();
        wr_t e;
        drain_half(8'd0, 128);
        n_checks++;
        if (USB_DONE !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_in_done: got USB_DONE=%b, expected 1", USB_DONE);
        end
        ENA          = 1'b1;
        SAMPLE_VALID = 1'b1;
        DIN          = 8'hC3;
        e.addr       = 8'd0;
        e.data       = 8'hC3;
        wr_q.push_back(e);
        tick();
        SAMPLE_VALID = 1'b0;
        n_checks++;
        if (WENA !== 1'b1 || WADDR !== 8'd0 || DROP_CNT !== 8'd2) begin
            n_fail++;
            $display("FAIL collide_write: got WENA=%b WADDR=%0d DROP_CNT=%0d, expected 1/0/2", WENA, WADDR, DROP_CNT);
        end
        n_checks++;
        if (dut.full_q[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_full0: got full0=%b, expected 0", dut.full_q[0]);
        end
        tick();
    endtask

    task automatic test_reset_mid_xfer();
        reset_dut();
        write_samples(128, 0);
        tick();
        drain_half(8'd0, 60);
        n_checks++;
        if (RADDR !== 8'd60) begin
            n_fail++;
            $display("FAIL midx_raddr: got RADDR=%0d, expected 60", RADDR);
        end
        RST          = 1'b1;
        ENA          = 1'b1;
        SAMPLE_VALID = 1'b1;
        USB_RDY      = 1'b1;
        USB_ACK      = 1'b1;
        #1;
        n_checks++;
        if ({WENA, WADDR, WDATA, USB_REQ, USB_HALF, RENA, RADDR, USB_DONE, OVERRUN, DROP_CNT} !== 38'd0) begin
            n_fail++;
            $display("FAIL midx_reset_outputs: got WENA=%b WADDR=%0d WDATA=%h REQ=%b HALF=%b RENA=%b RADDR=%0d DONE=%b OVR=%b DROP=%0d, expected all 0",
                     WENA, WADDR, WDATA, USB_REQ, USB_HALF, RENA, RADDR, USB_DONE, OVERRUN, DROP_CNT);
        end
        n_checks++;
        if (dut.full_q !== 2'b00 || rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL midx_discard: got full=%b pending_reads=%0d, expected 00/0", dut.full_q, rd_q.size());
        end
        reset_dut();
        write_samples(128, 0);
        tick();
        n_checks++;
        if ({USB_REQ, USB_HALF} !== 2'b10 || wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL midx_reoffer: got USB_REQ=%b USB_HALF=%b pending=%0d, expected 1/0/0",
                     USB_REQ, USB_HALF, wr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_fill_half0();
        test_drain();
        test_overrun();
        test_clr_ovr_drop();
        test_done_write_collide();
        test_reset_mid_xfer();
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
